// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, keeps one imem read in flight,
// buffers returned words for decode and flushes on redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        fetch_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(FIFO_DEPTH - 1);

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          outstanding;
  logic          drop;
  logic          err;
  logic [31:0]   buf_pc    [FIFO_DEPTH];
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          req_fire;
  logic          pop;
  logic          rsp;
  logic          push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Handshake terms; occ is the buffer occupancy after this cycle
  // settles, counting a live in-flight read as already resident.
  always_comb begin
    dec_valid = !rst && (count != '0) && !redirect_valid;
    pop       = dec_valid && dec_ready;
    rsp       = imem_rsp_valid && outstanding;
    push      = rsp && !drop && !redirect_valid;
    occ       = {1'b0, count}
              + {{CW{1'b0}}, outstanding && !drop}
              - {{CW{1'b0}}, pop};
    imem_req_valid = !rst && !redirect_valid && !err
                   && (!outstanding || imem_rsp_valid)
                   && (occ < DEPTH);
    req_fire  = imem_req_valid && imem_req_ready;
  end

  assign imem_req_addr = pc;
  assign dec_pc        = buf_pc[head];
  assign dec_instr     = buf_instr[head];
  assign fetch_err     = err;

  // Control state: pc, in-flight tracking, drop flag and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      err         <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      if (redirect_pc[1:0] != 2'b00) err <= 1'b1;
      if (rsp) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end else if (outstanding) begin
        drop <= 1'b1;
      end
    end else begin
      if (req_fire) begin
        pc          <= pc + 32'd4;
        inflight_pc <= pc;
      end
      if (req_fire)  outstanding <= 1'b1;
      else if (rsp)  outstanding <= 1'b0;
      if (rsp)       drop <= 1'b0;
      if (push)      tail <= nxt(tail);
      if (pop)       head <= nxt(head);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Buffer storage; contents need no reset since count gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[tail]    <= inflight_pc;
      buf_instr[tail] <= imem_rsp_data;
    end
  end

  // A push into a full buffer would silently lose an instruction.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && count == FULL));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, program-order model and
// directed scenarios for stall, latency, redirect, error and wrap.
module tb_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 3;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  bit toggle = 0;
  int cyc    = 0;

  logic [31:0] m_req;
  logic [31:0] m_dec;
  logic        m_err;
  logic [31:0] d0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_instr(dec_instr),
    .dec_pc(dec_pc),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dec(input string nm, input int maxc);
    int n = 0;
    while (!dec_valid && n < maxc) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk(nm, dec_valid, 1);
  endtask

  // Instruction memory: accepts on req_fire, answers after lat cycles.
  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
      end else begin
        if (imem_rsp_valid && mq.size() != 0) mq.delete(0);
        if (imem_req_valid && imem_req_ready) begin
          chk("one_outstanding", mq.size(), 0);
          mq.push_back('{imem_req_addr, cyc + lat});
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      imem_req_ready = toggle ? ((cyc % 3) != 0) : 1'b1;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(mq[0].a);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  // Program-order model: requests and decode both walk pc, pc+4, ...
  // from the last reset/redirect target; every word is memf(pc).
  initial begin
    logic hold;
    hold  = 1'b0;
    m_req = RPC;
    m_dec = RPC;
    m_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_dec_valid", dec_valid, 0);
        m_req = RPC;
        m_dec = RPC;
        m_err = 1'b0;
        hold  = 1'b0;
      end else if (redirect_valid) begin
        chk("redir_req_valid", imem_req_valid, 0);
        chk("redir_dec_valid", dec_valid, 0);
        chk("fetch_err", fetch_err, m_err);
        m_req = redirect_pc;
        m_dec = redirect_pc;
        if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
        hold = 1'b0;
      end else begin
        chk("fetch_err", fetch_err, m_err);
        if (hold) chk("hold_valid", imem_req_valid, 1);
        if (m_err) begin
          chk("err_req_valid", imem_req_valid, 0);
          chk("err_dec_valid", dec_valid, 0);
        end
        hold = 1'b0;
        if (imem_req_valid) begin
          chk("req_addr", imem_req_addr, m_req);
          if (imem_req_ready) m_req = m_req + 32'd4;
          else hold = 1'b1;
        end
        if (dec_valid) begin
          chk("dec_pc", dec_pc, m_dec);
          chk("dec_instr", dec_instr, memf(m_dec));
          if (dec_ready) m_dec = m_dec + 32'd4;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_fetch_err", fetch_err, 0);
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("c0_req_valid", imem_req_valid, 1);
    chk("c0_req_addr", imem_req_addr, 32'h100);
    chk("c0_dec_valid", dec_valid, 0);
    next();
    @(negedge clk);
    chk("c1_req_addr", imem_req_addr, 32'h104);
    chk("c1_dec_valid", dec_valid, 0);
    next();
    @(negedge clk);
    chk("c2_dec_valid", dec_valid, 1);
    chk("c2_dec_pc", dec_pc, 32'h100);
    chk("c2_req_addr", imem_req_addr, 32'h108);
    next();
    @(negedge clk);
    chk("c3_dec_pc", dec_pc, 32'h104);
    next();
    @(negedge clk);
    chk("c4_dec_pc", dec_pc, 32'h108);

    next();
    dec_ready = 1'b0;
    repeat (5) next();
    @(negedge clk);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_dec_valid", dec_valid, 1);
    chk("stall_dec_pc", dec_pc, 32'h10C);
    next();
    dec_ready = 1'b1;
    @(negedge clk);
    chk("rel_dec_pc0", dec_pc, 32'h10C);
    chk("rel_req_addr", imem_req_addr, 32'h118);
    next();
    @(negedge clk);
    chk("rel_dec_pc1", dec_pc, 32'h110);
    next();
    @(negedge clk);
    chk("rel_dec_pc2", dec_pc, 32'h114);

    next();
    lat    = 3;
    toggle = 1'b1;
    d0     = m_dec;
    repeat (40) next();
    chk("lat3_progress", 32'((m_dec - d0) >= 32'd20), 1);

    toggle    = 1'b0;
    lat       = 2;
    dec_ready = 1'b0;
    rst       = 1'b1;
    next();
    rst = 1'b0;
    repeat (5) next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    dec_ready      = 1'b1;
    @(negedge clk);
    chk("drop_pre_no_rsp", imem_rsp_valid, 0);
    next();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("drop_req_valid", imem_req_valid, 1);
    chk("drop_req_addr", imem_req_addr, 32'h200);
    chk("drop_dec_valid", dec_valid, 0);
    wait_dec("drop_dec_arrive", 10);
    chk("drop_dec_pc", dec_pc, 32'h200);

    next();
    lat = 1;
    repeat (3) next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    chk("same_rsp_pre", imem_rsp_valid, 1);
    next();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("same_req_valid", imem_req_valid, 1);
    chk("same_req_addr", imem_req_addr, 32'h300);
    wait_dec("same_dec_arrive", 10);
    chk("same_dec_pc", dec_pc, 32'h300);

    repeat (3) next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    next();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_fetch_err", fetch_err, 1);
    chk("mis_req_valid", imem_req_valid, 0);
    chk("mis_dec_valid", dec_valid, 0);
    repeat (4) next();
    @(negedge clk);
    chk("mis_sticky", fetch_err, 1);
    chk("mis_sticky_req", imem_req_valid, 0);
    next();
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    next();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("clr_fetch_err", fetch_err, 0);
    chk("clr_req_valid", imem_req_valid, 1);
    chk("clr_req_addr", imem_req_addr, RPC);

    repeat (3) next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    next();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_req_top", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_req_top_v", imem_req_valid, 1);
    next();
    @(negedge clk);
    chk("wrap_req_zero", imem_req_addr, 32'h0);
    chk("wrap_req_zero_v", imem_req_valid, 1);
    wait_dec("wrap_dec_arrive", 10);
    chk("wrap_dec_top", dec_pc, 32'hFFFF_FFFC);
    next();
    @(negedge clk);
    chk("wrap_dec_zero", dec_pc, 32'h0);
    chk("wrap_instr_zero", dec_instr, memf(32'h0));

    repeat (5) next();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage. It sits directly upstream of the controller and supplies it with pc/instr pairs. It owns the program counter and issues word reads to instruction memory, keeping at most one read outstanding. Returned words are buffered in a small FIFO and handed to decode over a valid/ready handshake. Redirects from branch/jal/jalr resolution flush all wrong-path state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FIFO_DEPTH, 2, decode buffer entries (>=2)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word address (bits [1:0] always 0)
imem_rsp_valid  in  1  read data valid; >=1 cycle after accept, in order
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  control-flow redirect (from branch/jal)
redirect_pc  in  32  redirect target
dec_valid  out  1  instruction available to controller
dec_ready  in  1  controller consumes this cycle
dec_instr  out  32  instruction word
dec_pc  out  32  address of dec_instr
fetch_err  out  1  sticky misaligned-redirect error

Behaviour:
- Reset (rst=1 at posedge): pc<=RESET_PC, FIFO empty, outstanding=0, drop=0, fetch_err=0. During/after reset: imem_req_valid=0, dec_valid=0 until conditions below hold.
- Fire terms: req_fire = imem_req_valid & imem_req_ready; pop = dec_valid & dec_ready; rsp = imem_rsp_valid & outstanding. imem_rsp_valid is ignored when outstanding=0.
- Issue: imem_req_valid = !redirect_valid & !fetch_err & (!outstanding | imem_rsp_valid) & (count - pop + (outstanding & !drop) < FIFO_DEPTH). imem_req_addr = pc. Combinational path dec_ready -> imem_req_valid is intentional.
- Once asserted, imem_req_valid/addr hold until req_fire. Only a redirect may withdraw them.
- On req_fire: pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0), outstanding<=1, inflight_pc<=pc.
- On rsp with drop=0: push {inflight_pc, imem_rsp_data}. On rsp with drop=1: discard and clear drop. Outstanding clears unless req_fire in the same cycle.
- Throughput: with 1-cycle memory latency and dec_ready=1, one instruction per cycle. First dec_valid comes 2 cycles after the first req_fire.
- FIFO: dec_valid = (count!=0) & !redirect_valid. dec_instr/dec_pc = head entry. Push and pop in the same cycle keep count. Push never occurs when full; an overflow is an assertion failure.
- Redirect (highest priority, single cycle):
  - FIFO flushed (count<=0); the head is not consumed that cycle.
  - pc<=redirect_pc; no request issued that cycle.
  - If outstanding and no rsp this cycle: drop<=1.
  - If rsp this cycle: data discarded, outstanding<=0.
  - Next request issues the cycle after the redirect (or on the dropped response's arrival cycle).
- Misaligned redirect (redirect_pc[1:0]!=0): fetch_err<=1 (sticky until rst), pc<=redirect_pc, no further requests. Pending response is dropped; FIFO stays empty.
- Redirect concurrent with rst: rst wins.
- rst mid-flight: all state cleared. A later stray imem_rsp_valid is ignored because outstanding=0.

Test Plan:
- Reset with RESET_PC=0x100, memory ready=1, latency 1, dec_ready=1 -> req addrs 0x100,0x104,0x108 on consecutive cycles; dec_pc 0x100 first valid 2 cycles after first accept; then one per cycle.
- dec_ready=0 for 6 cycles -> exactly FIFO_DEPTH entries buffered, imem_req_valid=0. Release -> pcs in order, none lost or duplicated.
- Memory latency 3 and imem_req_ready toggling -> addr stable while valid & !ready; one outstanding max; instr/pc pairs match memory.
- redirect_pc=0x200 while a read of 0x108 is outstanding and FIFO holds 0x100,0x104 -> those never reach decode; 0x108 response dropped; next dec_pc=0x200.
- Redirect in the same cycle as a response arrives -> response discarded; next req addr = redirect target on the following cycle.
- redirect_pc=0x202 -> fetch_err=1, no further requests, dec_valid=0. Pulse rst -> fetch_err=0, fetch resumes at RESET_PC.
- pc=0xFFFF_FFFC -> next req addr 0x0000_0000.
